cpu_seq: RTL and testbench

- Multicycle control sequencer for the 32-bit ARM-subset core.
- Fetches instructions over a req/ack instruction-memory port and latches them into an instruction register (IR).
- Evaluates the condition field against CPSR flags and steps the datapath through DECODE/EXEC/MEM/WB with one-cycle enable strobes.
- Owns the PC and a bus-timeout watchdog; drives the existing decoder, ALU, register-file and data-memory enables.

---
 rtl/cpu_seq.sv | 113 +++++++++++
 tb/tb_cpu_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// cpu_seq: multicycle fetch/decode/exec/mem/wb sequencer for the ARM-subset core,
// owning the PC, the instruction register and a bus-timeout watchdog.
module cpu_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT = 16,
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [3:0]  cpsr_in,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic        alu_en,
  output logic        cpsr_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        instr_done,
  output logic        undef,
  output logic        err
);
  localparam logic [2:0] RST = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, ERR = 3'd6;
  logic [2:0] state;
  logic [TO_W-1:0] cnt;
  logic [TO_W:0] cnt_nx;
  logic [31:0] pc, ir, br_tgt;
  logic pass, is_dp, is_ls, is_br, busy, to_hit;
  logic n, z, c, v;
  assign {n, z, c, v} = cpsr_in;
  always_comb begin
    pass = 1'b0;
    case (ir[31:28])
      4'h0: pass = z;
      4'h1: pass = !z;
      4'h2: pass = c;
      4'h3: pass = !c;
      4'h4: pass = n;
      4'h5: pass = !n;
      4'h6: pass = v;
      4'h7: pass = !v;
      4'h8: pass = c & !z;
      4'h9: pass = !c | z;
      4'ha: pass = n == v;
      4'hb: pass = n != v;
      4'hc: pass = !z & (n == v);
      4'hd: pass = z | (n != v);
      4'he: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
  assign is_dp = ir[27:26] == 2'b00;
  assign is_ls = ir[27:26] == 2'b01;
  assign is_br = ir[27:25] == 3'b101;
  assign br_tgt = pc + 32'd8 + {{6{ir[23]}}, ir[23:0], 2'b00};
  // counter only runs while a request is outstanding, so any state change clears it
  assign busy = (state == FETCH && !imem_ack) || (state == MEM && !dmem_ack);
  assign cnt_nx = {1'b0, cnt} + 1'b1;
  assign to_hit = (TIMEOUT != 0) && (cnt_nx >= (TO_W+1)'(TIMEOUT));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
      pc <= RESET_PC;
      ir <= '0;
      cnt <= '0;
    end else begin
      cnt <= busy ? cnt_nx[TO_W-1:0] : '0;
      case (state)
        RST: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            ir <= imem_rdata;
            state <= DECODE;
          end else if (to_hit) state <= ERR;
        end
        DECODE: begin
          state <= (pass && (is_dp || is_ls)) ? EXEC : FETCH;
          if (!pass || !(is_dp || is_ls)) pc <= (pass && is_br) ? br_tgt : pc + 32'd4;
        end
        EXEC: state <= is_dp ? WB : MEM;
        MEM: begin
          if (dmem_ack) begin
            state <= ir[20] ? WB : FETCH;
            if (!ir[20]) pc <= pc + 32'd4;
          end else if (to_hit) state <= ERR;
        end
        WB: begin
          pc <= pc + 32'd4;
          state <= FETCH;
        end
        default: state <= ERR;
      endcase
    end
  end
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign pc_out = pc;
  assign ir_out = ir;
  assign alu_en = state == EXEC;
  assign cpsr_we = alu_en && is_dp && ir[20];
  assign dmem_req = state == MEM;
  assign dmem_we = dmem_req && !ir[20];
  assign reg_we = state == WB;
  assign err = state == ERR;
  assign undef = state == DECODE && pass && !is_dp && !is_ls && !is_br;
  assign instr_done = (state == DECODE && (!pass || !(is_dp || is_ls))) || reg_we ||
                      (dmem_req && dmem_ack && !ir[20]);
endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: randomized and directed checks of cpu_seq against a per-instruction
// reference model (expected cycles, strobes and next PC from the instruction rules).
module tb_cpu_seq;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0;
  logic [31:0] imem_addr, imem_rdata = 0, ir_out, pc_out;
  logic [3:0] cpsr_in = 0;
  logic alu_en, cpsr_we, reg_we, instr_done, undef, err;
  int checks = 0, errors = 0;
  logic [31:0] m_pc;

  cpu_seq #(.RESET_PC(RPC), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .cpsr_in(cpsr_in), .ir_out(ir_out),
    .pc_out(pc_out), .alu_en(alu_en), .cpsr_we(cpsr_we), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .reg_we(reg_we), .instr_done(instr_done),
    .undef(undef), .err(err)
  );

  always #5 clk = ~clk;

  // ARM condition pairs: even code is the base test, odd code its negation
  function automatic bit cond_ok(logic [3:0] cc, logic [3:0] f);
    bit r;
    case (cc >> 1)
      0: r = f[2];
      1: r = f[1];
      2: r = f[3];
      3: r = f[0];
      4: r = f[1] && !f[2];
      5: r = f[3] == f[0];
      6: r = !f[2] && (f[3] == f[0]);
      default: r = 1;
    endcase
    return cc[0] ? !r : r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    imem_ack = 0;
    dmem_ack = 0;
    @(negedge clk);
    rst_n = 1;
    m_pc = RPC;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input int iw, input int dw);
    int cls, e_cyc, e_a, e_c, e_r, e_u, e_d, cyc, icnt, dcnt, na, nc, nr, nu, nd, off;
    bit started, done, addr_bad, we_bad, err_seen, p;
    logic [31:0] e_pc;
    cls = int'(ins[27:25]);
    p = cond_ok(ins[31:28], fl);
    e_a = 0; e_c = 0; e_r = 0; e_u = 0; e_d = 0;
    e_pc = m_pc + 32'd4;
    e_cyc = iw + 2;
    if (p && cls <= 1) begin
      e_a = 1; e_c = int'(ins[20]); e_r = 1; e_cyc = iw + 4;
    end else if (p && cls <= 3) begin
      e_a = 1; e_d = dw + 1; e_r = int'(ins[20]); e_cyc = iw + dw + 4 + int'(ins[20]);
    end else if (p && cls == 5) begin
      off = $signed(ins[23:0]);
      e_pc = m_pc + 32'd8 + 32'(off * 4);
    end else if (p) e_u = 1;
    cpsr_in = fl;
    started = 0; done = 0; addr_bad = 0; we_bad = 0; err_seen = 0;
    cyc = 0; icnt = 0; dcnt = 0; na = 0; nc = 0; nr = 0; nu = 0; nd = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      imem_ack = imem_req && icnt == iw;
      imem_rdata = imem_ack ? ins : $urandom;
      dmem_ack = dmem_req && dcnt == dw;
      #1;
      if (imem_req) begin
        started = 1;
        icnt++;
        if (imem_addr !== m_pc) addr_bad = 1;
      end
      if (started) cyc++;
      if (dmem_req) begin
        dcnt++;
        nd++;
        if (dmem_we !== !ins[20]) we_bad = 1;
      end
      na += int'(alu_en); nc += int'(cpsr_we); nr += int'(reg_we); nu += int'(undef);
      if (err) err_seen = 1;
      done = instr_done;
    end
    checks += 11;
    if (!done) begin errors++; $display("FAIL done ins=%h got=0 want=1", ins); end
    if (cyc !== e_cyc) begin errors++; $display("FAIL cycles ins=%h got=%0d want=%0d", ins, cyc, e_cyc); end
    if (na !== e_a) begin errors++; $display("FAIL alu_en ins=%h got=%0d want=%0d", ins, na, e_a); end
    if (nc !== e_c) begin errors++; $display("FAIL cpsr_we ins=%h got=%0d want=%0d", ins, nc, e_c); end
    if (nr !== e_r) begin errors++; $display("FAIL reg_we ins=%h got=%0d want=%0d", ins, nr, e_r); end
    if (nu !== e_u) begin errors++; $display("FAIL undef ins=%h got=%0d want=%0d", ins, nu, e_u); end
    if (nd !== e_d) begin errors++; $display("FAIL dmem_req ins=%h got=%0d want=%0d", ins, nd, e_d); end
    if (we_bad || addr_bad) begin errors++; $display("FAIL we/addr ins=%h got=%0d%0d want=00", ins, we_bad, addr_bad); end
    if (err_seen) begin errors++; $display("FAIL no_err ins=%h got=1 want=0", ins); end
    if (ir_out !== ins) begin errors++; $display("FAIL ir ins=%h got=%h want=%h", ins, ir_out, ins); end
    @(posedge clk);
    #1;
    if (pc_out !== e_pc) begin errors++; $display("FAIL pc ins=%h got=%h want=%h", ins, pc_out, e_pc); end
    m_pc = e_pc;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (pc_out !== RPC || ir_out !== 0) begin errors++; $display("FAIL reset_regs got=%h/%h want=%h/0", pc_out, ir_out, RPC); end
    if ({imem_req, dmem_req, dmem_we, alu_en, cpsr_we, reg_we, instr_done, undef, err} !== 9'b0) begin
      errors++; $display("FAIL reset_outs got=%b want=0", {imem_req, dmem_req, dmem_we, alu_en, cpsr_we, reg_we, instr_done, undef, err});
    end
    @(negedge clk);
    rst_n = 1;
    m_pc = RPC;
    #1;
    if (imem_req !== 0) begin errors++; $display("FAIL rst_state got=%b want=0", imem_req); end
  endtask

  task automatic test_dp();
    run_instr(32'hE0811002, 4'h0, 0, 0);
    run_instr(32'hE0911002, 4'h0, 2, 0);
    run_instr(32'hE0811002, 4'h0, 3, 0);
  endtask

  task automatic test_branch();
    run_instr(32'h0A000002, 4'b0100, 0, 0);
    run_instr(32'h0A000002, 4'b0000, 1, 0);
    run_instr(32'hF0811002, 4'hF, 0, 0);
  endtask

  task automatic test_ldst();
    run_instr(32'hE5912000, 4'h0, 0, 3);
    run_instr(32'hE5812000, 4'h0, 0, 0);
    run_instr(32'hE5812000, 4'h0, 1, 3);
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run_instr(32'hEAFFFFC0, 4'h0, 0, 0);
    run_instr(32'hEAFFFFFE, 4'h0, 0, 0);
    run_instr(32'hEAFFFFFB, 4'h0, 0, 0);
    run_instr(32'hEC000000, 4'h0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_instr($urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_timeout();
    int nreq;
    bit hit;
    do_reset();
    nreq = 0; hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      imem_ack = 0;
      #1;
      if (err) hit = 1;
      else nreq += int'(imem_req);
    end
    checks += 3;
    if (!hit || nreq !== 4) begin errors++; $display("FAIL timeout_cycles got=%0d want=4", nreq); end
    if (imem_req !== 0) begin errors++; $display("FAIL timeout_req got=%b want=0", imem_req); end
    repeat (3) @(negedge clk);
    imem_ack = 1;
    #1;
    if (err !== 1 || imem_req !== 0) begin errors++; $display("FAIL err_sticky got=%b%b want=10", err, imem_req); end
    do_reset();
    #1;
    checks++;
    if (err !== 0) begin errors++; $display("FAIL err_clear got=%b want=0", err); end
    run_instr(32'hE0811002, 4'h0, 3, 0);
  endtask

  task automatic test_async_reset();
    bit hit;
    do_reset();
    cpsr_in = 0;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      imem_ack = imem_req;
      imem_rdata = 32'hE5912000;
      dmem_ack = 0;
      #1;
      hit = dmem_req;
    end
    checks += 3;
    if (!hit) begin errors++; $display("FAIL reach_mem got=0 want=1"); end
    rst_n = 0;
    #1;
    if (dmem_req !== 0 || imem_req !== 0) begin errors++; $display("FAIL async_drop got=%b%b want=00", dmem_req, imem_req); end
    @(negedge clk);
    rst_n = 1;
    imem_ack = 0;
    m_pc = RPC;
    #1;
    if (pc_out !== RPC) begin errors++; $display("FAIL async_pc got=%h want=%h", pc_out, RPC); end
    run_instr(32'hE0811002, 4'h0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_dp();
    test_branch();
    test_ldst();
    test_pc_wrap();
    test_random();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
